wb_update: RTL and testbench
============================

// Module: wb_update
// PURPOSE
//  Mini-batch weight/bias update stage, directly downstream of the delta
//  weight/bias accumulators. Counts accepted training samples; after BATCH
//  samples (or on flush) it walks all parameters serially, w <= sat(w - dw),
//  then pulses a clear to the accumulators. Holds the live 2-3-2 network
//  parameters and drives them to the forward and backprop datapath.
// PARAMETERS
//  N_IN    2   input count
//  N_HL_P  3   hidden perceptrons
//  N_OUT   2   output perceptrons
//  WIDTH   32  signed fixed-point word width
//  BATCH   4   samples per update, >=1
//  CNT_W   8   sample counter width, 2**CNT_W > BATCH
// PORTS
//  clk         in   1                  clock, rising edge
//  rst         in   1                  synchronous reset, active-low
//  i_sample_vld in  1                  1-cycle pulse: accumulators absorbed a sample
//  i_flush     in   1                  force update with partial batch
//  i_load      in   1                  load initial parameters (IDLE only)
//  i_init      in   P*WIDTH            initial parameters, P=17, packed as below
//  i_d_wght_hd in   N_HL_P*N_IN*WIDTH  accumulated hidden weight deltas
//  i_d_bias_hd in   N_HL_P*WIDTH       accumulated hidden bias deltas
//  i_d_wght_o  in   N_HL_P*N_OUT*WIDTH accumulated output weight deltas
//  i_d_bias_o  in   N_OUT*WIDTH        accumulated output bias deltas
//  o_wght_hd   out  N_HL_P*N_IN*WIDTH  current hidden weights
//  o_bias_hd   out  N_HL_P*WIDTH       current hidden biases
//  o_wght_o    out  N_HL_P*N_OUT*WIDTH current output weights
//  o_bias_o    out  N_OUT*WIDTH        current output biases
//  o_ready     out  1                  1 = samples accepted; gates accumulator en
//  o_busy      out  1                  1 in UPDATE or CLEAR
//  o_acc_clr   out  1                  1-cycle clear pulse to accumulators
//  o_done      out  1                  1-cycle pulse: update finished
// BEHAVIOUR
//  Reset (rst=0 at edge): all parameters 0, count 0, state IDLE, o_ready=1,
//   o_busy=o_acc_clr=o_done=0. Reset mid-update aborts; params return to 0.
//  Flat index k, 0..16, element 0 in the lowest slice of each bus:
//   0-5 wght_hd, 6-8 bias_hd, 9-14 wght_o, 15-16 bias_o. i_init uses the same order.
//  FSM: IDLE -> UPDATE -> CLEAR -> DONE -> IDLE.
//  IDLE: o_ready=1.
//   - i_load: copies all of i_init and zeros count.
//     Priority over sample/flush; a sample pulse in that cycle is dropped.
//   - i_sample_vld: count+1.
//     When count+1==BATCH, or i_flush is also set: count<=0, go to UPDATE.
//   - i_flush alone: goes to UPDATE only if count>0, else ignored.
//  UPDATE: o_ready=0, o_busy=1; index counter k=0..16, one parameter per cycle.
//   p[k] <= sat(p[k] - d[k]).
//   Subtraction at WIDTH+1 bits, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//   Deltas are stable because upstream en is gated by o_ready.
//   i_sample_vld, i_flush and i_load are ignored. After k=16 go to CLEAR.
//  CLEAR: o_acc_clr=1, o_busy=1, o_ready=0, one cycle.
//  DONE: o_done=1, o_ready=0, o_busy=0, one cycle; then IDLE.
//  Latency: triggering sample at cycle t -> param k written at edge t+1+k,
//   o_acc_clr high in cycle t+18, o_done in t+19, o_ready=1 from t+20.
//  Outputs are registered; a parameter changes only at its write edge.
// TESTING
//  1) reset, i_load with p[k]=k<<16, then 4 sample pulses with d[k]=0x10000:
//     update starts after the 4th; p[k]=(k-1)<<16; o_acc_clr at t+18, o_done at t+19.
//  2) p[0]=0x80000001, d[0]=0x00000010 -> p[0] clamps to 0x80000000.
//     p[1]=0x7FFFFFF0, d[1]=0xFFFFFF00 -> p[1] clamps to 0x7FFFFFFF.
//  3) 2 samples then i_flush -> update runs.
//     i_flush with count 0 -> nothing happens; o_busy stays 0.
//  4) i_load and i_sample_vld in the same cycle -> params loaded, count stays 0.
//     Pulses during UPDATE are ignored; o_ready=0 throughout.
//  5) rst low at k=8 of an update -> all params 0, IDLE, o_ready=1 next cycle,
//     no o_acc_clr or o_done pulse.
//  6) BATCH=1: every sample triggers an update; back-to-back pulses are ignored
//     until o_ready returns.

Source files
------------

// File: rtl/wb_update.sv
// Mini-batch parameter update for the 2-3-2 network: counts samples, then walks
// every parameter once applying p <= sat(p - delta) and clears the accumulators.
//
// state  | meaning
// IDLE   | accepting samples, load allowed
// UPDATE | one parameter per cycle, index k = 0..P-1
// CLEAR  | one-cycle clear pulse to the accumulators
// DONE   | one-cycle completion pulse
module wb_update #(
  parameter int N_IN   = 2,
  parameter int N_HL_P = 3,
  parameter int N_OUT  = 2,
  parameter int WIDTH  = 32,
  parameter int BATCH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_sample_vld,
  input  logic                            i_flush,
  input  logic                            i_load,
  input  logic [(N_HL_P*N_IN+N_HL_P+N_HL_P*N_OUT+N_OUT)*WIDTH-1:0] i_init,
  input  logic [N_HL_P*N_IN*WIDTH-1:0]    i_d_wght_hd,
  input  logic [N_HL_P*WIDTH-1:0]         i_d_bias_hd,
  input  logic [N_HL_P*N_OUT*WIDTH-1:0]   i_d_wght_o,
  input  logic [N_OUT*WIDTH-1:0]          i_d_bias_o,
  output logic [N_HL_P*N_IN*WIDTH-1:0]    o_wght_hd,
  output logic [N_HL_P*WIDTH-1:0]         o_bias_hd,
  output logic [N_HL_P*N_OUT*WIDTH-1:0]   o_wght_o,
  output logic [N_OUT*WIDTH-1:0]          o_bias_o,
  output logic                            o_ready,
  output logic                            o_busy,
  output logic                            o_acc_clr,
  output logic                            o_done
);

  localparam int P   = N_HL_P*N_IN + N_HL_P + N_HL_P*N_OUT + N_OUT;
  localparam int K_W = $clog2(P);
  localparam logic [K_W-1:0]   K_LAST  = K_W'(P-1);
  localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(BATCH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_CLEAR  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] prm [P];
  logic [WIDTH-1:0] dlt [P];
  logic [P*WIDTH-1:0] d_all;
  logic [P*WIDTH-1:0] p_all;
  logic [WIDTH-1:0] p_k;
  logic [WIDTH-1:0] d_k;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sat;

  // Flat order k: hidden weights, hidden biases, output weights, output biases
  assign d_all = {i_d_bias_o, i_d_wght_o, i_d_bias_hd, i_d_wght_hd};
  assign {o_bias_o, o_wght_o, o_bias_hd, o_wght_hd} = p_all;

  for (genvar j = 0; j < P; j++) begin : g_flat
    assign dlt[j] = d_all[j*WIDTH +: WIDTH];
    assign p_all[j*WIDTH +: WIDTH] = prm[j];
  end

  assign p_k     = prm[k];
  assign d_k     = dlt[k];
  assign cnt_inc = cnt + 1'b1;

  // Sign-extended subtract; top two bits disagree only on overflow
  always_comb begin
    diff = {p_k[WIDTH-1], p_k} - {d_k[WIDTH-1], d_k};
    sat  = diff[WIDTH-1:0];
    if (diff[WIDTH] != diff[WIDTH-1])
      sat = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      k     <= '0;
      cnt   <= '0;
      for (int j = 0; j < P; j++) prm[j] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          k <= '0;
          if (i_load) begin
            cnt <= '0;
            for (int j = 0; j < P; j++) prm[j] <= i_init[j*WIDTH +: WIDTH];
          end else if (i_sample_vld) begin
            if (cnt_inc == BATCH_C || i_flush) begin
              cnt   <= '0;
              state <= S_UPDATE;
            end else begin
              cnt <= cnt_inc;
            end
          end else if (i_flush && cnt != '0) begin
            cnt   <= '0;
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          prm[k] <= sat;
          if (k == K_LAST) state <= S_CLEAR;
          else             k     <= k + 1'b1;
        end
        S_CLEAR: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ready   = (state == S_IDLE);
  assign o_busy    = (state == S_UPDATE) || (state == S_CLEAR);
  assign o_acc_clr = (state == S_CLEAR);
  assign o_done    = (state == S_DONE);

endmodule

// File: tb/tb_wb_update.sv
// Directed bench for wb_update: default BATCH=4 instance plus a BATCH=1 instance
// sharing the same stimulus.
module tb_wb_update;

  logic clk, rst, vld, flush, load;
  logic [543:0] init_f, d_f;
  logic [31:0]  init_a [17];
  logic [31:0]  d_a [17];

  logic [191:0] wh0, wh1, wo0, wo1;
  logic [95:0]  bh0, bh1;
  logic [63:0]  bo0, bo1;
  logic rdy0, busy0, clr0, done0;
  logic rdy1, busy1, clr1, done1;
  logic [543:0] p0_f, p1_f;

  int n_chk = 0;
  int n_bad = 0;

  always_comb begin
    init_f = '0;
    d_f    = '0;
    for (int k = 0; k < 17; k++) begin
      init_f[k*32 +: 32] = init_a[k];
      d_f[k*32 +: 32]    = d_a[k];
    end
  end

  assign p0_f = {bo0, wo0, bh0, wh0};
  assign p1_f = {bo1, wo1, bh1, wh1};

  wb_update dut0 (
    .clk(clk), .rst(rst), .i_sample_vld(vld), .i_flush(flush), .i_load(load),
    .i_init(init_f), .i_d_wght_hd(d_f[191:0]), .i_d_bias_hd(d_f[287:192]),
    .i_d_wght_o(d_f[479:288]), .i_d_bias_o(d_f[543:480]),
    .o_wght_hd(wh0), .o_bias_hd(bh0), .o_wght_o(wo0), .o_bias_o(bo0),
    .o_ready(rdy0), .o_busy(busy0), .o_acc_clr(clr0), .o_done(done0)
  );

  wb_update #(.BATCH(1)) dut1 (
    .clk(clk), .rst(rst), .i_sample_vld(vld), .i_flush(flush), .i_load(load),
    .i_init(init_f), .i_d_wght_hd(d_f[191:0]), .i_d_bias_hd(d_f[287:192]),
    .i_d_wght_o(d_f[479:288]), .i_d_bias_o(d_f[543:480]),
    .o_wght_hd(wh1), .o_bias_hd(bh1), .o_wght_o(wo1), .o_bias_o(bo1),
    .o_ready(rdy1), .o_busy(busy1), .o_acc_clr(clr1), .o_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] p0(input int k);
    return p0_f[k*32 +: 32];
  endfunction

  function automatic logic [31:0] p1(input int k);
    return p1_f[k*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; vld = 1'b0; flush = 1'b0; load = 1'b0;
    for (int k = 0; k < 17; k++) begin init_a[k] = '0; d_a[k] = '0; end
    tick();
    // reset state
    chk("rst_ready", rdy0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_clr", clr0, 0);
    chk("rst_done", done0, 0);
    chk("rst_p0", p0(0), 0);
    chk("rst_p16", p0(16), 0);
    rst = 1'b1;

    // 1) full batch, latency
    for (int k = 0; k < 17; k++) begin init_a[k] = k << 16; d_a[k] = 32'h10000; end
    do_load();
    chk("t1_load_p5", p0(5), 32'h50000);
    for (int i = 0; i < 3; i++) begin
      pulse();
      chk("t1_busy_pre", busy0, 0);
    end
    pulse();
    chk("t1_busy", busy0, 1);
    chk("t1_ready", rdy0, 0);
    chk("t1_p0_unwritten", p0(0), 0);
    tick();
    chk("t1_p0_written", p0(0), 32'hFFFF0000);
    chk("t1_p1_unwritten", p0(1), 32'h10000);
    repeat (16) tick();
    chk("t1_clr_t18", clr0, 1);
    chk("t1_busy_t18", busy0, 1);
    chk("t1_done_t18", done0, 0);
    tick();
    chk("t1_done_t19", done0, 1);
    chk("t1_clr_t19", clr0, 0);
    chk("t1_busy_t19", busy0, 0);
    chk("t1_ready_t19", rdy0, 0);
    tick();
    chk("t1_ready_t20", rdy0, 1);
    chk("t1_done_t20", done0, 0);
    for (int k = 0; k < 17; k++) chk($sformatf("t1_p%0d", k), p0(k), 32'((k - 1) * 65536));

    // 2) saturation
    for (int k = 0; k < 17; k++) begin init_a[k] = '0; d_a[k] = '0; end
    init_a[0] = 32'h80000001; d_a[0] = 32'h00000010;
    init_a[1] = 32'h7FFFFFF0; d_a[1] = 32'hFFFFFF00;
    init_a[2] = 32'd5;        d_a[2] = 32'd7;
    do_load();
    repeat (4) pulse();
    repeat (19) tick();
    chk("t2_neg_clamp", p0(0), 32'h80000000);
    chk("t2_pos_clamp", p0(1), 32'h7FFFFFFF);
    chk("t2_plain_sub", p0(2), 32'hFFFFFFFE);
    chk("t2_zero_delta", p0(3), 0);

    // 3) flush with partial batch, then flush with empty count
    for (int k = 0; k < 17; k++) begin init_a[k] = '0; d_a[k] = 32'd1; end
    do_load();
    repeat (2) pulse();
    chk("t3_busy_pre", busy0, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3_flush_busy", busy0, 1);
    repeat (19) tick();
    chk("t3_ready", rdy0, 1);
    chk("t3_p16", p0(16), 32'hFFFFFFFF);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3_empty_flush_busy", busy0, 0);
    tick();
    chk("t3_empty_flush_busy2", busy0, 0);
    chk("t3_empty_p16", p0(16), 32'hFFFFFFFF);

    // 4) load wins over sample; pulses during update ignored
    for (int k = 0; k < 17; k++) begin init_a[k] = 32'(k * 256); d_a[k] = 32'h10; end
    vld = 1'b1; load = 1'b1; tick(); vld = 1'b0; load = 1'b0;
    chk("t4_load_p3", p0(3), 32'h300);
    repeat (3) pulse();
    chk("t4_count_zero", busy0, 0);
    pulse();
    chk("t4_trigger", busy0, 1);
    for (int k = 0; k < 17; k++) init_a[k] = 32'hAAAA;
    vld = 1'b1; flush = 1'b1; load = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("t4_ready_upd%0d", i), rdy0, 0);
      tick();
    end
    vld = 1'b0; flush = 1'b0; load = 1'b0;
    chk("t4_clr", clr0, 1);
    repeat (2) tick();
    chk("t4_ready_back", rdy0, 1);
    chk("t4_p3", p0(3), 32'h2F0);
    chk("t4_p0", p0(0), 32'hFFFFFFF0);
    repeat (3) pulse();
    chk("t4_no_count_in_upd", busy0, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (19) tick();

    // 5) reset in the middle of an update
    for (int k = 0; k < 17; k++) begin init_a[k] = 32'(k + 1); d_a[k] = '0; end
    do_load();
    repeat (4) pulse();
    repeat (8) tick();
    chk("t5_busy_k8", busy0, 1);
    do_reset();
    chk("t5_ready", rdy0, 1);
    chk("t5_busy", busy0, 0);
    for (int k = 0; k < 17; k++) chk($sformatf("t5_p%0d", k), p0(k), 0);
    for (int i = 0; i < 12; i++) begin
      chk("t5_no_clr", clr0, 0);
      chk("t5_no_done", done0, 0);
      tick();
    end

    // 6) BATCH=1 instance: each sample triggers, back-to-back ignored
    do_reset();
    for (int k = 0; k < 17; k++) begin init_a[k] = '0; d_a[k] = 32'd1; end
    do_load();
    vld = 1'b1;
    tick();
    chk("t6_busy", busy1, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t6_ready_low", rdy1, 0);
      tick();
    end
    vld = 1'b0;
    repeat (14) tick();
    chk("t6_ready_back", rdy1, 1);
    chk("t6_p0_once", p1(0), 32'hFFFFFFFF);
    chk("t6_p16_once", p1(16), 32'hFFFFFFFF);
    pulse();
    chk("t6_busy2", busy1, 1);
    repeat (19) tick();
    chk("t6_p0_twice", p1(0), 32'hFFFFFFFE);
    chk("t6_ready2", rdy1, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
